// File: rtl/object_centroid_scanner_if.sv
// Result record channel of object_centroid_scanner: one {id, area, cx, cy} record per transfer.
// A record moves on the rising edge where out_valid and out_ready are both 1; the master holds it stable until then.
`ifndef LBL_WIDTH
`define LBL_WIDTH 8
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 16
`endif

interface object_centroid_scanner_if #(
  parameter int LBL_WIDTH = `LBL_WIDTH,
  parameter int LOC_SIZE  = `LOC_SIZE
);
  logic                 out_valid;
  logic                 out_ready;
  logic [LBL_WIDTH-1:0] out_id;
  logic [LOC_SIZE-1:0]  out_area;
  logic [LOC_SIZE-1:0]  out_cx;
  logic [LOC_SIZE-1:0]  out_cy;

  modport master (
    output out_valid, out_id, out_area, out_cx, out_cy,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_id, out_area, out_cx, out_cy,
    output out_ready
  );
endinterface

// File: rtl/object_centroid_scanner.sv
// Sweeps the labeling stage's object table after each frame and emits one centroid record per object.
// Define MIN_AREA_FILTER_EN to also drop objects whose area is below MIN_AREA.
`ifndef LBL_WIDTH
`define LBL_WIDTH 8
`endif
`ifndef LOC_SIZE
`define LOC_SIZE 16
`endif

module object_centroid_scanner #(
  parameter int LBL_WIDTH = `LBL_WIDTH,
  parameter int LOC_SIZE  = `LOC_SIZE,
  parameter int RD_LAT    = 2,
  parameter int MIN_AREA  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [LBL_WIDTH-1:0]      num_labels,
  output logic [LBL_WIDTH-1:0]      obj_id,
  input  logic [LOC_SIZE-1:0]       obj_area,
  input  logic [LOC_SIZE-1:0]       obj_x,
  input  logic [LOC_SIZE-1:0]       obj_y,
  object_centroid_scanner_if.master res,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    DIVIDE  = 3'd3,
    EMIT    = 3'd4,
    NEXT    = 3'd5
  } state_t;

  // One counter serves both the table read wait and the divider bit index.
  localparam int CNT_MAX = (RD_LAT > LOC_SIZE) ? RD_LAT : LOC_SIZE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [LBL_WIDTH-1:0] num_labels_q;
  logic [LOC_SIZE-1:0]  area_q, xq_q, yq_q, xr_q, yr_q;

  logic                 skip, fetch_last, div_last, id_last, sweep_empty;
  logic [LBL_WIDTH-1:0] id_inc;
  logic [LOC_SIZE:0]    x_sh, y_sh;
  logic [LOC_SIZE-1:0]  x_sub, y_sub, xq_d, yq_d, xr_d, yr_d;
  logic                 x_ge, y_ge;

`ifdef MIN_AREA_FILTER_EN
  assign skip = (obj_area == '0) || (obj_area < LOC_SIZE'(MIN_AREA));
`else
  assign skip = (obj_area == '0);
`endif

  assign fetch_last  = (cnt_q == CNT_W'(RD_LAT - 1));
  assign div_last    = (cnt_q == CNT_W'(LOC_SIZE - 1));
  assign id_inc      = obj_id + LBL_WIDTH'(1);
  assign id_last     = (id_inc == num_labels_q);
  assign sweep_empty = (num_labels <= LBL_WIDTH'(1));

  // Restoring divider step: the quotient bit shifts into the dividend register as its MSB leaves.
  always_comb begin
    x_sh  = {xr_q, xq_q[LOC_SIZE-1]};
    y_sh  = {yr_q, yq_q[LOC_SIZE-1]};
    x_ge  = (x_sh >= {1'b0, area_q});
    y_ge  = (y_sh >= {1'b0, area_q});
    x_sub = x_sh[LOC_SIZE-1:0] - area_q;
    y_sub = y_sh[LOC_SIZE-1:0] - area_q;
    xr_d  = x_ge ? x_sub : x_sh[LOC_SIZE-1:0];
    yr_d  = y_ge ? y_sub : y_sh[LOC_SIZE-1:0];
    xq_d  = {xq_q[LOC_SIZE-2:0], x_ge};
    yq_d  = {yq_q[LOC_SIZE-2:0], y_ge};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !sweep_empty) state_d = FETCH;
      FETCH:   if (fetch_last) state_d = CAPTURE;
      CAPTURE: state_d = skip ? NEXT : DIVIDE;
      DIVIDE:  if (div_last) state_d = EMIT;
      EMIT:    if (res.out_ready) state_d = NEXT;
      NEXT:    state_d = id_last ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign res.out_valid = (state_q == EMIT);
  assign dbg_state     = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      obj_id       <= '0;
      num_labels_q <= '0;
      cnt_q        <= '0;
      area_q       <= '0;
      xq_q         <= '0;
      yq_q         <= '0;
      xr_q         <= '0;
      yr_q         <= '0;
      done         <= 1'b0;
      res.out_id   <= '0;
      res.out_area <= '0;
      res.out_cx   <= '0;
      res.out_cy   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (sweep_empty) begin
              done <= 1'b1;
            end else begin
              obj_id       <= LBL_WIDTH'(1);
              num_labels_q <= num_labels;
              cnt_q        <= '0;
            end
          end
        end
        FETCH: cnt_q <= cnt_q + CNT_W'(1);
        CAPTURE: begin
          area_q <= obj_area;
          xq_q   <= obj_x;
          yq_q   <= obj_y;
          xr_q   <= '0;
          yr_q   <= '0;
          cnt_q  <= '0;
        end
        DIVIDE: begin
          xq_q  <= xq_d;
          yq_q  <= yq_d;
          xr_q  <= xr_d;
          yr_q  <= yr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (div_last) begin
            res.out_id   <= obj_id;
            res.out_area <= area_q;
            res.out_cx   <= xq_d;
            res.out_cy   <= yq_d;
          end
        end
        NEXT: begin
          obj_id <= id_inc;
          cnt_q  <= '0;
          if (id_last) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
